// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes a MIPS-I instruction into ALU op/operands and
// holds it in a single valid/ready slot with stall, flush and an issue counter.
module alu_issue_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       alu_ctrl,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       dest_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);
  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        beq;
    logic        bne;
    logic        ill;
  } slot_t;

  slot_t            slot_q, slot_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [5:0]  op, fn;
  logic [31:0] sx, zx, sh;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign sx = {{16{instr[15]}}, instr[15:0]};
  assign zx = {16'h0, instr[15:0]};
  assign sh = {27'h0, instr[10:6]};

  // I-type defaults (A=rs, B=sx, dest=rt) are overridden per opcode below.
  always_comb begin
    slot_d      = '0;
    slot_d.a    = rs_data;
    slot_d.b    = sx;
    slot_d.dest = instr[20:16];
    slot_d.rw   = 1'b1;
    unique case (op)
      6'h00: begin
        slot_d.b    = rt_data;
        slot_d.dest = instr[15:11];
        unique case (fn)
          6'h20, 6'h21: slot_d.ctrl = 5'd0;
          6'h22, 6'h23: slot_d.ctrl = 5'd1;
          6'h24:        slot_d.ctrl = 5'd2;
          6'h25:        slot_d.ctrl = 5'd3;
          6'h26:        slot_d.ctrl = 5'd4;
          6'h27:        slot_d.ctrl = 5'd5;
          6'h2A:        slot_d.ctrl = 5'd6;
          6'h00: begin slot_d.ctrl = 5'd7; slot_d.a = sh; end
          6'h02: begin slot_d.ctrl = 5'd8; slot_d.a = sh; end
          6'h03: begin slot_d.ctrl = 5'd9; slot_d.a = sh; end
          6'h04: begin slot_d.ctrl = 5'd7; slot_d.a = {27'h0, rs_data[4:0]}; end
          6'h06: begin slot_d.ctrl = 5'd8; slot_d.a = {27'h0, rs_data[4:0]}; end
          6'h07: begin slot_d.ctrl = 5'd9; slot_d.a = {27'h0, rs_data[4:0]}; end
          default: begin slot_d = '0; slot_d.ill = 1'b1; end
        endcase
      end
      6'h08, 6'h09: slot_d.ctrl = 5'd0;
      6'h0A:        slot_d.ctrl = 5'd6;
      6'h0C: begin slot_d.ctrl = 5'd2; slot_d.b = zx; end
      6'h0D: begin slot_d.ctrl = 5'd3; slot_d.b = zx; end
      6'h0E: begin slot_d.ctrl = 5'd4; slot_d.b = zx; end
      6'h0F: begin slot_d.ctrl = 5'd7; slot_d.a = 32'd16; slot_d.b = zx; end
      6'h23: slot_d.mr = 1'b1;
      6'h2B: begin slot_d.mw = 1'b1; slot_d.rw = 1'b0; end
      6'h04: begin slot_d.ctrl = 5'd1; slot_d.b = rt_data; slot_d.rw = 1'b0; slot_d.beq = 1'b1; end
      6'h05: begin slot_d.ctrl = 5'd1; slot_d.b = rt_data; slot_d.rw = 1'b0; slot_d.bne = 1'b1; end
      default: begin slot_d = '0; slot_d.ill = 1'b1; end
    endcase
    // $zero is never a real writeback target
    if (slot_d.dest == 5'd0) slot_d.rw = 1'b0;
  end

  assign in_ready = !reset && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) slot_q <= slot_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_ctrl    = slot_q.ctrl;
  assign alu_a       = slot_q.a;
  assign alu_b       = slot_q.b;
  assign dest_reg    = slot_q.dest;
  assign reg_write   = slot_q.rw;
  assign mem_read    = slot_q.mr;
  assign mem_write   = slot_q.mw;
  assign branch_eq   = slot_q.beq;
  assign branch_ne   = slot_q.bne;
  assign illegal     = slot_q.ill;
  assign issue_count = cnt_q;
endmodule
